audio_dc_mixer: RTL
===================

Name: audio_dc_mixer

Overview:
- Stereo post-processing stage between the core's audio outputs (signed 16-bit left/right from atari800top) and the top-level AUDIO_L/AUDIO_R pins.
- Decimates the audio to a fixed sample rate and removes DC offset with a first-order fixed-point IIR high-pass.
- Applies a click-free soft mute/unmute gain ramp and saturates the result back to signed 16 bits.
- Uses a single time-multiplexed datapath, so left and right are processed on consecutive cycles.

Parameters:
- SAMPLE_DIV, 1184, clk_sys cycles per audio sample tick (≈48 kHz at ~56.8 MHz); legal range 8..65535.
- K, 10, high-pass pole shift: Y -= Y>>>K each sample; legal range 4..14.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_l  in  16  signed left sample from the core, sampled at tick.
- in_r  in  16  signed right sample from the core.
- bypass  in  1  1 = output raw input instead of the filtered value; filter state still updates.
- mute  in  1  1 = gain ramps toward 0, 0 = gain ramps toward 64.
- out_l  out  16  signed left output, held between updates.
- out_r  out  16  signed right output.
- sample_stb  out  1  one-cycle pulse in the cycle out_l/out_r update.

Behaviour:
- Reset values: out_l=0, out_r=0, sample_stb=0, gain=0 (soft start), divider=0, x_prev_l/r=0, Y_l/Y_r=0, FSM=IDLE.
- Divider counts 0..SAMPLE_DIV-1. The tick fires in the cycle the divider wraps to 0.
- FSM states: IDLE -> CAP -> CALC_L -> CALC_R -> OUT -> IDLE, advancing one state per cycle.
- IDLE: on tick, go to CAP.
- CAP: latch in_l/in_r into x_l/x_r. Input changes after this cycle do not affect the current sample.
- CALC_L, then CALC_R (same datapath, one channel per cycle):
  - d = x - x_prev, 17-bit signed.
  - Y_new = Y + (d<<<8) - (Y>>>K). Y is 26-bit signed with 8 fraction bits; >>> is an arithmetic (flooring) shift.
  - Y_new saturates to [-2^25, 2^25-1].
  - Update x_prev=x and Y=Y_new.
- OUT:
  - gain steps 1 toward its target (64 if mute=0, 0 if mute=1) and clamps at 0 and 64.
  - Per channel: v = bypass ? x : (Y_new>>>8), 18-bit signed.
  - p = v*gain_new, 25-bit signed.
  - out = sat16(p>>>6), clamped to [-32768, 32767].
  - Register out_l and out_r and pulse sample_stb=1 for this cycle only.
- Latency: sample_stb asserts exactly 4 cycles after the tick cycle. Since SAMPLE_DIV>=8, a tick never arrives while the FSM is busy. If one does (illegal parameter), it is ignored.
- gain=64 gives exact passthrough of v, saturated; gain=0 gives 0.
- Reset mid-sequence (any state) returns everything to reset values on the next edge. No partial output update and no stb.
- Toggling bypass or mute changes only the next OUT computation; there are no glitches between ticks.

Test Plan:
- Reset, then mute=0 and in_l=in_r=0 for 70 ticks: outputs stay 0; sample_stb period = SAMPLE_DIV cycles; each stb lands 4 cycles after the tick; gain reaches 64 at tick 64.
- At full gain, step in_l 0->1000: out_l=1000 on the first tick, then 999 on the next (Y=255750), decaying monotonically toward 0. in_r=0 keeps out_r=0.
- At full gain, step in_l=-1000: first output -1000, second -1000 (floor: Y=-256000+250 -> -999.02 floored to -1000). Confirms flooring.
- bypass=1 with constant in_r=12345 at full gain: out_r=12345 every tick. Release bypass: out_r shows the decayed filtered value, not a step.
- Full-scale alternation in_l = +32767 / -32768 each tick with bypass=0: outputs clamp at +32767 / -32768 with no wrap.
- Sustained in_l=20000 at gain 64, then assert mute: out_l decreases by gain steps of 1 per tick, reaching 0 after 64 ticks. Assert reset between CAP and OUT: no stb, and all outputs read 0 on the next cycle.

Source files
------------

// File: rtl/audio_dc_mixer_if.sv
`default_nettype none
// ============================================================================
// Module   : audio_dc_mixer_if
// Brief    : Stereo sample bus between the core audio and the output mixer.
// Revision : 1.0
// ============================================================================
interface audio_dc_mixer_if;
    logic signed [15:0] in_l;
    logic signed [15:0] in_r;
    logic               bypass;
    logic               mute;
    logic signed [15:0] out_l;
    logic signed [15:0] out_r;
    logic               sample_stb;

    modport master (
        output in_l, in_r, bypass, mute,
        input  out_l, out_r, sample_stb
    );

    modport slave (
        input  in_l, in_r, bypass, mute,
        output out_l, out_r, sample_stb
    );
endinterface
`default_nettype wire

// File: rtl/audio_dc_mixer.sv
`default_nettype none
// ============================================================================
// Module   : audio_dc_mixer
// Brief    : Decimating DC-blocking high-pass with soft mute ramp and 16-bit
//            saturation; one shared datapath serves left then right.
// Revision : 1.0
// ============================================================================
module audio_dc_mixer #(
    parameter int SAMPLE_DIV = 1184,
    parameter int K          = 10
) (
    input  wire             clk_sys,
    input  wire             reset,
    audio_dc_mixer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CAP    = 3'd1,
        S_CALC_L = 3'd2,
        S_CALC_R = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    localparam logic [15:0] c_div_max   = 16'(SAMPLE_DIV - 1);
    localparam logic [6:0]  c_gain_full = 7'd64;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_cap;
    logic               w_calc_l;
    logic               w_calc_r;

    logic [15:0]        r_div;
    logic               w_tick;

    logic signed [15:0] r_x_l;
    logic signed [15:0] r_x_r;
    logic signed [15:0] r_xp_l;
    logic signed [15:0] r_xp_r;
    logic signed [25:0] r_y_l;
    logic signed [25:0] r_y_r;
    logic [6:0]         r_gain;
    logic signed [15:0] r_out_l;
    logic signed [15:0] r_out_r;
    logic               r_stb;

    logic signed [15:0] w_x;
    logic signed [15:0] w_xp;
    logic signed [25:0] w_y;
    logic signed [16:0] w_d;
    logic signed [25:0] w_y_shr;
    logic signed [27:0] w_sum;
    logic signed [25:0] w_y_new;

    logic [6:0]         w_gain_new;
    logic signed [7:0]  w_gain_s;
    logic signed [17:0] w_v_l;
    logic signed [17:0] w_v_r;
    logic signed [25:0] w_p_l;
    logic signed [25:0] w_p_r;

    function automatic logic signed [25:0] sat_y(input logic signed [27:0] s);
        if (s > 28'sd33554431)
            return 26'sh1FFFFFF;
        else if (s < -28'sd33554432)
            return 26'sh2000000;
        else
            return s[25:0];
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [25:0] v);
        if (v > 26'sd32767)
            return 16'sh7FFF;
        else if (v < -26'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    assign w_tick = (r_div == c_div_max);

    always_ff @(posedge clk_sys) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // Ticks arriving outside IDLE are dropped.
    always_comb begin
        w_state_next = r_state;
        w_cap        = 1'b0;
        w_calc_l     = 1'b0;
        w_calc_r     = 1'b0;
        case (r_state)
            S_IDLE:   if (w_tick) w_state_next = S_CAP;
            S_CAP: begin
                w_cap        = 1'b1;
                w_state_next = S_CALC_L;
            end
            S_CALC_L: begin
                w_calc_l     = 1'b1;
                w_state_next = S_CALC_R;
            end
            S_CALC_R: begin
                w_calc_r     = 1'b1;
                w_state_next = S_OUT;
            end
            S_OUT:    w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_x  = r_x_l;
        w_xp = r_xp_l;
        w_y  = r_y_l;
        if (w_calc_r) begin
            w_x  = r_x_r;
            w_xp = r_xp_r;
            w_y  = r_y_r;
        end
    end

    assign w_d     = {w_x[15], w_x} - {w_xp[15], w_xp};
    assign w_y_shr = w_y >>> K;
    assign w_sum   = {{2{w_y[25]}}, w_y}
                   + {{3{w_d[16]}}, w_d, 8'd0}
                   - {{2{w_y_shr[25]}}, w_y_shr};
    assign w_y_new = sat_y(w_sum);

    always_comb begin
        w_gain_new = r_gain;
        if (bus.mute) begin
            if (r_gain != 7'd0)
                w_gain_new = r_gain - 7'd1;
        end else if (r_gain < c_gain_full) begin
            w_gain_new = r_gain + 7'd1;
        end
    end

    // Left Y is already registered during CALC_R; right Y is still on the
    // shared datapath, so both channels are scaled in that cycle and land
    // together with the strobe in OUT.
    assign w_gain_s = {1'b0, w_gain_new};
    assign w_v_l    = bus.bypass ? {{2{r_x_l[15]}}, r_x_l} : r_y_l[25:8];
    assign w_v_r    = bus.bypass ? {{2{r_x_r[15]}}, r_x_r} : w_y_new[25:8];
    assign w_p_l    = 26'(w_v_l) * 26'(w_gain_s);
    assign w_p_r    = 26'(w_v_r) * 26'(w_gain_s);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_div   <= '0;
            r_x_l   <= '0;
            r_x_r   <= '0;
            r_xp_l  <= '0;
            r_xp_r  <= '0;
            r_y_l   <= '0;
            r_y_r   <= '0;
            r_gain  <= '0;
            r_out_l <= '0;
            r_out_r <= '0;
            r_stb   <= 1'b0;
        end else begin
            r_div <= w_tick ? 16'd0 : r_div + 16'd1;
            r_stb <= w_calc_r;
            if (w_cap) begin
                r_x_l <= bus.in_l;
                r_x_r <= bus.in_r;
            end
            if (w_calc_l) begin
                r_xp_l <= r_x_l;
                r_y_l  <= w_y_new;
            end
            if (w_calc_r) begin
                r_xp_r  <= r_x_r;
                r_y_r   <= w_y_new;
                r_gain  <= w_gain_new;
                r_out_l <= sat16(w_p_l >>> 6);
                r_out_r <= sat16(w_p_r >>> 6);
            end
        end
    end

    assign bus.out_l      = r_out_l;
    assign bus.out_r      = r_out_r;
    assign bus.sample_stb = r_stb;

endmodule
`default_nettype wire
